// File: rtl/cpu16_isa_pkg.sv
// Shared cpu16 ISA definitions: opcodes, instruction classes, field widths,
// loader error codes and loader state encoding.
package cpu16_isa_pkg;

  localparam int OP_W    = 5;
  localparam int FIELD_W = 8;
  localparam int CC_W    = OP_W + 2 * FIELD_W;
  localparam int INSTR_W = 16;

  localparam logic [OP_W-1:0] OP_NOP    = 5'b00000;
  localparam logic [OP_W-1:0] OP_LD     = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST     = 5'b00100;
  localparam logic [OP_W-1:0] OP_JUMP   = 5'b00101;
  localparam logic [OP_W-1:0] OP_LDI    = 5'b00110;
  localparam logic [OP_W-1:0] OP_ALU_LO = 5'b01000;
  localparam logic [OP_W-1:0] OP_ALU_HI = 5'b01110;
  localparam logic [OP_W-1:0] OP_ADD    = 5'b10000;
  localparam logic [OP_W-1:0] OP_OR     = 5'b10011;
  localparam logic [OP_W-1:0] OP_ADDI   = 5'b10100;
  localparam logic [OP_W-1:0] OP_SUBI   = 5'b10101;
  localparam logic [OP_W-1:0] OP_BRZ    = 5'b10110;
  localparam logic [OP_W-1:0] OP_CALL   = 5'b10111;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_RESERVED = 2'b11;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_J, CLS_ILLEGAL} op_class_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_t;

  typedef struct packed {
    state_t    state;
    op_class_t last_cls;
  } loader_dbg_t;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t c;
    c = CLS_ILLEGAL;
    case (op)
      OP_NOP, OP_LD, OP_ST:  c = CLS_R;
      OP_ADDI, OP_SUBI, OP_LDI: c = CLS_I;
      OP_BRZ, OP_CALL, OP_JUMP: c = CLS_J;
      default: begin
        if ((op >= OP_ALU_LO && op <= OP_ALU_HI) || (op >= OP_ADD && op <= OP_OR))
          c = CLS_R;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cc_instr_loader_if.sv
// Control-code stream and instruction-memory write bus of cc_instr_loader.
// cc handshake: a beat transfers on a rising edge where cc_valid && cc_ready;
// the source holds cc_data/cc_last stable while cc_valid is high and unaccepted.
interface cc_instr_loader_if #(parameter int ADDR_W = 8);
  import cpu16_isa_pkg::*;

  logic               cc_valid;
  logic               cc_ready;
  logic [CC_W-1:0]    cc_data;
  logic               cc_last;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (
    output cc_valid, cc_data, cc_last,
    input  cc_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cc_valid, cc_data, cc_last,
    output cc_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cc_field_pack.sv
// Combinational packer: control code {op, A, B} -> 16-bit instruction word.
// CC_LOADER_STRICT_CHECK_EN enables the reserved-field-nonzero flag.
import cpu16_isa_pkg::*;

module cc_field_pack (
  input  logic [CC_W-1:0]    cc,
  output logic [INSTR_W-1:0] word,
  output op_class_t          cls,
  output logic               illegal,
  output logic               rsvd_nz
);

  logic [OP_W-1:0]    op;
  logic [FIELD_W-1:0] a;
  logic [FIELD_W-1:0] b;
  logic [FIELD_W-1:0] f;

  assign op      = cc[CC_W-1 -: OP_W];
  assign a       = cc[2*FIELD_W-1 -: FIELD_W];
  assign b       = cc[FIELD_W-1:0];
  assign cls     = op_class(op);
  assign illegal = (cls == CLS_ILLEGAL);

  always_comb begin
    f = '0;
    case (cls)
      CLS_R:   f = a;
      CLS_I:   f = {a[7:4], b[3:0]};
      CLS_J:   f = b;
      default: f = '0;
    endcase
  end

  assign word = {op, 3'b000, f};

`ifdef CC_LOADER_STRICT_CHECK_EN
  // Fields the class does not pack must be zero.
  always_comb begin
    rsvd_nz = 1'b0;
    case (cls)
      CLS_R:   rsvd_nz = |b;
      CLS_I:   rsvd_nz = |{a[3:0], b[7:4]};
      CLS_J:   rsvd_nz = |a;
      default: rsvd_nz = 1'b0;
    endcase
  end
`else
  assign rsvd_nz = 1'b0;
`endif

endmodule

// File: rtl/cc_instr_loader.sv
// Packs a stream of control codes into instruction words and writes them to
// instruction memory from a programmable start address (see CC_LOADER_STRICT_CHECK_EN).
import cpu16_isa_pkg::*;

module cc_instr_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  cc_instr_loader_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output loader_dbg_t       dbg
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]    wc_q, wc_d;
  logic [1:0]         code_q, code_d;
  op_class_t          cls_q, cls_d;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [INSTR_W-1:0] pk_word;
  op_class_t          pk_cls;
  logic               pk_illegal;
  logic               pk_rsvd_nz;

  logic accept;
  logic at_top;
  logic start_oor;

  cc_field_pack u_pack (
    .cc      (bus.cc_data),
    .word    (pk_word),
    .cls     (pk_cls),
    .illegal (pk_illegal),
    .rsvd_nz (pk_rsvd_nz)
  );

  assign accept    = bus.cc_valid && ready_q;
  assign at_top    = (ptr_q == ADDR_W'(DEPTH - 1));
  assign start_oor = ({1'b0, start_addr} >= (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wc_q    <= '0;
      code_q  <= ERR_NONE;
      cls_q   <= CLS_R;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      code_q  <= code_d;
      cls_q   <= cls_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    code_d  = code_q;
    cls_d   = cls_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          cls_d = pk_cls;
          if (pk_illegal) begin
            state_d = ST_ERR;
            code_d  = ERR_ILLEGAL;
          end else if (pk_rsvd_nz) begin
            state_d = ST_ERR;
            code_d  = ERR_RESERVED;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = pk_word;
            wc_d    = wc_q + 1'b1;
            // Pointer parks at the top address rather than wrapping.
            ptr_d   = at_top ? ptr_q : ptr_q + 1'b1;
            if (bus.cc_last) begin
              state_d = ST_DONE;
            end else if (at_top) begin
              state_d = ST_ERR;
              code_d  = ERR_OVERFLOW;
            end
          end
        end
      end
      default: begin
        if (start) begin
          wc_d   = '0;
          code_d = ERR_NONE;
          if (start_oor) begin
            state_d = ST_ERR;
            code_d  = ERR_OVERFLOW;
          end else begin
            state_d = ST_RUN;
            ptr_d   = start_addr;
          end
        end
      end
    endcase
  end

  // Status flags are computed from the next state so they register in step with it.
  always_comb begin
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  assign bus.cc_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign word_count    = wc_q;
  assign dbg.state     = state_q;
  assign dbg.last_cls  = cls_q;

endmodule

// File: tb/tb_cc_instr_loader.sv
// Directed self-checking bench for cc_instr_loader: a 256-deep instance and a
// 4-deep instance for capacity boundaries; honours CC_LOADER_STRICT_CHECK_EN.
module tb_cc_instr_loader;

  logic       clk;
  logic       rst;
  logic       start, s_start;
  logic [7:0] start_addr, s_start_addr;
  logic       busy, done, err, s_busy, s_done, s_err;
  logic [1:0] err_code, s_err_code;
  logic [8:0] wc, s_wc;
  logic [3:0] dbg, s_dbg;

  int checks = 0;
  int errors = 0;

  cc_instr_loader_if #(.ADDR_W(8)) bus ();
  cc_instr_loader_if #(.ADDR_W(8)) sbus ();

  cc_instr_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .word_count(wc), .dbg(dbg)
  );

  cc_instr_loader #(.ADDR_W(8), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .start_addr(s_start_addr), .bus(sbus),
    .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code), .word_count(s_wc), .dbg(s_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] cc(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.cc_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, err_code, wc, dbg} !== 42'd0) begin
      errors++;
      $display("FAIL reset_big: got %h required 0", {bus.cc_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, err_code, wc, dbg});
    end
    checks++;
    if ({sbus.cc_ready, sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_busy, s_done, s_err, s_err_code, s_wc, s_dbg} !== 42'd0) begin
      errors++;
      $display("FAIL reset_small: got %h required 0", {sbus.cc_ready, sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_busy, s_done, s_err, s_err_code, s_wc, s_dbg});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; start_addr = 8'h10;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, err, bus.cc_ready, wc} !== {4'b1001, 9'd0}) begin
      errors++; $display("FAIL b2b_arm: got %b required 1001_000000000", {busy, done, err, bus.cc_ready, wc});
    end
    bus.cc_valid = 1'b1; bus.cc_data = cc(5'b10000, 8'h3A, 8'h00);
    tick();
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, wc} !== {1'b1, 8'h10, 16'h803A, 9'd1}) begin
      errors++; $display("FAIL b2b_w0: got %h required %h", {bus.mem_we, bus.mem_addr, bus.mem_wdata, wc}, {1'b1, 8'h10, 16'h803A, 9'd1});
    end
    bus.cc_data = cc(5'b10100, 8'h50, 8'h07);
    tick();
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, wc} !== {1'b1, 8'h11, 16'hA057, 9'd2}) begin
      errors++; $display("FAIL b2b_w1: got %h required %h", {bus.mem_we, bus.mem_addr, bus.mem_wdata, wc}, {1'b1, 8'h11, 16'hA057, 9'd2});
    end
    bus.cc_data = cc(5'b00101, 8'h00, 8'h42); bus.cc_last = 1'b1;
    tick();
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h12, 16'h2842}) begin
      errors++; $display("FAIL b2b_w2: got %h required %h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 8'h12, 16'h2842});
    end
    bus.cc_valid = 1'b0; bus.cc_last = 1'b0;
    checks++;
    if ({done, busy, err, bus.cc_ready, wc} !== {4'b1000, 9'd3}) begin
      errors++; $display("FAIL b2b_done: got %b required 1000_000000011", {done, busy, err, bus.cc_ready, wc});
    end
    tick();
    checks++;
    if ({bus.mem_we, done} !== 2'b01) begin
      errors++; $display("FAIL b2b_idle_we: got %b required 01", {bus.mem_we, done});
    end
  endtask

  task automatic test_illegal_op();
    start = 1'b1; start_addr = 8'h20;
    tick();
    start = 1'b0;
    bus.cc_valid = 1'b1; bus.cc_data = cc(5'b10000, 8'h3A, 8'h00);
    tick();
    checks++;
    if ({bus.mem_we, bus.mem_addr, done} !== {1'b1, 8'h20, 1'b0}) begin
      errors++; $display("FAIL illegal_first: got %h required %h", {bus.mem_we, bus.mem_addr, done}, {1'b1, 8'h20, 1'b0});
    end
    bus.cc_data = cc(5'b11111, 8'h12, 8'h34);
    tick();
    bus.cc_valid = 1'b0;
    checks++;
    if ({bus.mem_we, err, err_code, bus.cc_ready, busy, wc} !== {6'b010100, 9'd1}) begin
      errors++; $display("FAIL illegal_err: got %b required 010100_000000001", {bus.mem_we, err, err_code, bus.cc_ready, busy, wc});
    end
    tick();
    checks++;
    if ({bus.mem_we, err} !== 2'b01) begin
      errors++; $display("FAIL illegal_hold: got %b required 01", {bus.mem_we, err});
    end
  endtask

  task automatic test_overflow();
    s_start = 1'b1; s_start_addr = 8'd2;
    tick();
    s_start = 1'b0;
    sbus.cc_valid = 1'b1; sbus.cc_data = cc(5'b10000, 8'h01, 8'h00);
    tick();
    checks++;
    if ({sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_err, s_wc} !== {1'b1, 8'd2, 16'h8001, 1'b0, 9'd1}) begin
      errors++; $display("FAIL ovf_w2: got %h required %h", {sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_err, s_wc}, {1'b1, 8'd2, 16'h8001, 1'b0, 9'd1});
    end
    sbus.cc_data = cc(5'b10000, 8'h02, 8'h00);
    tick();
    checks++;
    if ({sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_err, s_err_code, sbus.cc_ready, s_wc} !== {1'b1, 8'd3, 16'h8002, 4'b1100, 9'd2}) begin
      errors++; $display("FAIL ovf_w3: got %h required %h", {sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_err, s_err_code, sbus.cc_ready, s_wc}, {1'b1, 8'd3, 16'h8002, 4'b1100, 9'd2});
    end
    sbus.cc_data = cc(5'b10000, 8'h03, 8'h00);
    tick();
    sbus.cc_valid = 1'b0;
    checks++;
    if ({sbus.mem_we, s_err, s_err_code, s_wc} !== {4'b0110, 9'd2}) begin
      errors++; $display("FAIL ovf_third: got %b required 0110_000000010", {sbus.mem_we, s_err, s_err_code, s_wc});
    end
    s_start = 1'b1; s_start_addr = 8'd4;
    tick();
    s_start = 1'b0;
    checks++;
    if ({s_busy, s_err, s_err_code, s_wc} !== {4'b0110, 9'd0}) begin
      errors++; $display("FAIL ovf_bad_start: got %b required 0110_000000000", {s_busy, s_err, s_err_code, s_wc});
    end
    s_start = 1'b1; s_start_addr = 8'd3;
    tick();
    s_start = 1'b0;
    checks++;
    if ({s_busy, s_err, s_err_code, s_done} !== 5'b10000) begin
      errors++; $display("FAIL ovf_rearm: got %b required 10000", {s_busy, s_err, s_err_code, s_done});
    end
    sbus.cc_valid = 1'b1; sbus.cc_last = 1'b1; sbus.cc_data = cc(5'b10000, 8'h04, 8'h00);
    tick();
    sbus.cc_valid = 1'b0; sbus.cc_last = 1'b0;
    checks++;
    if ({sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_done, s_err, s_wc} !== {1'b1, 8'd3, 16'h8004, 2'b10, 9'd1}) begin
      errors++; $display("FAIL ovf_last_top: got %h required %h", {sbus.mem_we, sbus.mem_addr, sbus.mem_wdata, s_done, s_err, s_wc}, {1'b1, 8'd3, 16'h8004, 2'b10, 9'd1});
    end
  endtask

  task automatic test_valid_toggle();
    int k;
    logic [7:0] iv;
    k = 0;
    start = 1'b1; start_addr = 8'h40;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      iv = 8'(i);
      bus.cc_valid = (i % 2 == 0) && (i < 5);
      bus.cc_data  = cc(5'b10000, iv, 8'h00);
      bus.cc_last  = (i == 4);
      start        = (i == 3);
      tick();
      checks++;
      if (bus.mem_we !== ((i % 2 == 0) && (i < 5))) begin
        errors++; $display("FAIL toggle_we[%0d]: got %b required %b", i, bus.mem_we, (i % 2 == 0) && (i < 5));
      end
      if ((i % 2 == 0) && (i < 5)) begin
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {8'h40 + 8'(k), 16'h8000 | 16'(i)}) begin
          errors++; $display("FAIL toggle_data[%0d]: got %h required %h", i, {bus.mem_addr, bus.mem_wdata}, {8'h40 + 8'(k), 16'h8000 | 16'(i)});
        end
        k++;
      end
      if (i == 3) begin
        checks++;
        if ({busy, wc} !== {1'b1, 9'd2}) begin
          errors++; $display("FAIL toggle_start_ignored: got %h required %h", {busy, wc}, {1'b1, 9'd2});
        end
      end
    end
    start = 1'b0; bus.cc_valid = 1'b0; bus.cc_last = 1'b0;
    checks++;
    if ({done, busy, wc} !== {2'b10, 9'd3}) begin
      errors++; $display("FAIL toggle_done: got %b required 10_000000011", {done, busy, wc});
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; start_addr = 8'h80;
    tick();
    start = 1'b0;
    bus.cc_valid = 1'b1; bus.cc_data = cc(5'b10000, 8'h11, 8'h00);
    tick();
    checks++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b1, 8'h80}) begin
      errors++; $display("FAIL rstmid_write: got %h required %h", {bus.mem_we, bus.mem_addr}, {1'b1, 8'h80});
    end
    rst = 1'b1; bus.cc_data = cc(5'b10000, 8'h22, 8'h00);
    tick();
    checks++;
    if ({bus.cc_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, err_code, wc, dbg} !== 42'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h required 0", {bus.cc_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, err_code, wc, dbg});
    end
    rst = 1'b0; bus.cc_valid = 1'b0;
    tick();
    checks++;
    if ({bus.mem_we, busy} !== 2'b00) begin
      errors++; $display("FAIL rstmid_after: got %b required 00", {bus.mem_we, busy});
    end
  endtask

  task automatic test_strict_fields();
    start = 1'b1; start_addr = 8'h30;
    tick();
    start = 1'b0;
    bus.cc_valid = 1'b1; bus.cc_data = cc(5'b10000, 8'h3A, 8'h01);
    tick();
    bus.cc_valid = 1'b0;
`ifdef CC_LOADER_STRICT_CHECK_EN
    checks++;
    if ({bus.mem_we, err, err_code, wc} !== {4'b0111, 9'd0}) begin
      errors++; $display("FAIL strict_rsvd: got %b required 0111_000000000", {bus.mem_we, err, err_code, wc});
    end
`else
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, err, wc} !== {1'b1, 8'h30, 16'h803A, 1'b0, 9'd1}) begin
      errors++; $display("FAIL strict_ignored: got %h required %h", {bus.mem_we, bus.mem_addr, bus.mem_wdata, err, wc}, {1'b1, 8'h30, 16'h803A, 1'b0, 9'd1});
    end
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; start_addr = '0;
    s_start = 1'b0; s_start_addr = '0;
    bus.cc_valid = 1'b0; bus.cc_data = '0; bus.cc_last = 1'b0;
    sbus.cc_valid = 1'b0; sbus.cc_data = '0; sbus.cc_last = 1'b0;
    test_reset();
    test_back_to_back();
    test_illegal_op();
    test_overflow();
    test_valid_toggle();
    test_reset_mid_run();
    test_strict_fields();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_instr_loader.md
Name: cc_instr_loader

Overview:
- Inverse of the instruction decoder: accepts a stream of 21-bit control codes {op[4:0], A[7:0], B[7:0]} and packs each into a 16-bit instruction word.
- Writes the packed words sequentially into instruction memory from a programmable start address.
- Sits between the program-load/debug port and the instruction RAM.
- Checks opcode legality and capacity; stops with an error code on violation.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words (highest legal address DEPTH-1, DEPTH <= 2**ADDR_W).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; arms the loader at start_addr.
- start_addr  input  ADDR_W  first memory address, sampled when start is accepted.
- cc_valid  input  1  control-code beat valid.
- cc_ready  output  1  loader accepts a beat this cycle.
- cc_data  input  21  control code {op, A, B}.
- cc_last  input  1  marks the final beat of a program.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  packed instruction.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- err_code  output  2  01 = illegal opcode, 10 = overflow, 11 = reserved bits nonzero.
- word_count  output  ADDR_W+1  number of words written since the last start.

Behaviour:
- All outputs are registered.
- Reset values: cc_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_code=00, word_count=0. State=IDLE, pointer=0.
- States:
  - IDLE: start -> RUN (ptr=start_addr, word_count=0). If start_addr >= DEPTH, go to ERR with code 10 instead.
  - RUN: cc_ready=1. A beat is accepted on cc_valid && cc_ready.
  - DONE, ERR: start re-arms exactly as from IDLE and clears err/err_code/done. Otherwise the state holds.
  - start in RUN is ignored.
- Packing: mem_wdata = {op, 3'b000, F}, where F depends on the opcode class.
  - Class R (00000, 00001, 00100, 01000-01110, 10000-10011): F = A.
  - Class I (10100, 10101, 00110): F = {A[7:4], B[3:0]}.
  - Class J (10110, 10111, 00101): F = B.
  - Any other opcode is illegal.
- Latency: a beat accepted in cycle N produces mem_we=1 in cycle N+1, with mem_addr = ptr and the packed word on mem_wdata. ptr and word_count increment in the same cycle. mem_we is a single-cycle pulse per beat.
- Back-to-back beats sustain one write per cycle.
- Illegal opcode: no write; go to ERR code 01 in N+1; cc_ready drops in N+1.
- Accepted beat with cc_last=1: write, then DONE in N+1.
- Capacity: a beat written to DEPTH-1 without cc_last causes the write and then ERR code 10 in N+1. No address wrap ever occurs.
- If cc_last and the DEPTH-1 write coincide, the result is DONE, not ERR.
- rst asserted mid-RUN: no mem_we in the cycle after rst. All registers take their reset values.

Optional Feature:
- Macro: CC_LOADER_STRICT_CHECK_EN.
- When defined, the unused control-code fields must be zero:
  - Class R: B == 0.
  - Class I: {A[3:0], B[7:4]} == 0.
  - Class J: A == 0.
  - A violation gives no write and ERR code 11.
- When undefined, the unused fields are ignored and code 11 is never produced.

Decomposition:
- Package cpu16_isa_pkg holds:
  - the 5-bit opcode constants shared with the decoder;
  - the class enum R/I/J/ILLEGAL;
  - field widths;
  - the err_code constants;
  - the state encoding.
- One combinational sub-module, cc_field_pack: takes a control code and outputs the 16-bit word, the class, the illegal flag and the reserved-nonzero flag. The FSM, pointer and handshake stay in cc_instr_loader.

Test Plan:
- start, start_addr=8'h10; beats ADD {10000, 8'h3A, 8'h00}, then ADD_I {10100, 8'h50, 8'h07}, then JUMP {00101, 8'h00, 8'h42} with cc_last -> writes 16'h803A@10, 16'hA057@11, 16'h2842@12 on consecutive cycles; then done=1, word_count=3.
- Beat with op 5'b11111 after one good beat -> one write only; err=1, err_code=01; cc_ready=0 next cycle.
- DEPTH=4, start_addr=2; three beats, no cc_last -> writes @2 and @3; err_code=10; third beat never accepted.
- cc_valid toggling every other cycle, plus start asserted mid-RUN -> start ignored; writes only on accepted beats; addresses contiguous.
- Assert rst the cycle after a beat is accepted -> no mem_we; all outputs at reset values.
- With CC_LOADER_STRICT_CHECK_EN, beat ADD {10000, 8'h3A, 8'h01} -> err_code=11, no write. Without the macro -> writes 16'h803A.
